// File: rtl/div_seq_ctrl.sv
// Sequencer around a combinational divider: registers operands, holds magnitudes for
// DIV_LATENCY cycles, applies RISC-V sign/special-case rules. Option: DIV_SEQ_CTRL_FAST_PATH_EN.
module div_seq_ctrl #(
  parameter int DIV_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] dv_in1,
  output logic [31:0] dv_in2,
  output logic        dv_en,
  input  logic [31:0] dv_low,
  input  logic [31:0] dv_high
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] dv_in1_reg, dv_in1_next;
  logic [31:0] dv_in2_reg, dv_in2_next;
  logic [31:0] result_reg, result_next;
  logic [31:0] spec_res_reg, spec_res_next;
  logic        special_reg, special_next;
  logic        is_rem_reg, is_rem_next;
  logic        q_neg_reg, q_neg_next;
  logic        r_neg_reg, r_neg_next;

  // Request decode; anything outside the valid DIV/REM codes falls back to DIVU.
  logic        in_signed, in_rem, in_neg_a, in_neg_b, in_div0, in_ovf;
  logic [31:0] in_spec_res;
  assign in_signed   = (funct3 == 3'b100) || (funct3 == 3'b110);
  assign in_rem      = funct3[2] & funct3[1];
  assign in_neg_a    = in_signed & rs1[31];
  assign in_neg_b    = in_signed & rs2[31];
  assign in_div0     = (rs2 == 32'd0);
  assign in_ovf      = in_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign in_spec_res = in_div0 ? (in_rem ? rs1 : 32'hFFFF_FFFF)
                               : (in_rem ? 32'd0 : 32'h8000_0000);

  logic [31:0] q_val, r_val;
  assign q_val = q_neg_reg ? -dv_low  : dv_low;
  assign r_val = r_neg_reg ? -dv_high : dv_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      dv_in1_reg   <= 32'd0;
      dv_in2_reg   <= 32'd0;
      result_reg   <= 32'd0;
      spec_res_reg <= 32'd0;
      special_reg  <= 1'b0;
      is_rem_reg   <= 1'b0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dv_in1_reg   <= dv_in1_next;
      dv_in2_reg   <= dv_in2_next;
      result_reg   <= result_next;
      spec_res_reg <= spec_res_next;
      special_reg  <= special_next;
      is_rem_reg   <= is_rem_next;
      q_neg_reg    <= q_neg_next;
      r_neg_reg    <= r_neg_next;
    end
  end

  always_comb begin
    logic accept;
    accept        = 1'b0;
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dv_in1_next   = dv_in1_reg;
    dv_in2_next   = dv_in2_reg;
    result_next   = result_reg;
    spec_res_next = spec_res_reg;
    special_next  = special_reg;
    is_rem_next   = is_rem_reg;
    q_neg_next    = q_neg_reg;
    r_neg_next    = r_neg_reg;

    case (state_reg)
      IDLE: accept = start;
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next  = DONE;
          // Special cases ignore whatever the divider produced.
          result_next = special_reg ? spec_res_reg : (is_rem_reg ? r_val : q_val);
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        accept = start;
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      dv_in1_next   = in_neg_a ? -rs1 : rs1;
      dv_in2_next   = in_neg_b ? -rs2 : rs2;
      is_rem_next   = in_rem;
      q_neg_next    = in_neg_a ^ in_neg_b;
      r_neg_next    = in_neg_a;
      special_next  = in_div0 | in_ovf;
      spec_res_next = in_spec_res;
      cnt_next      = 4'(DIV_LATENCY - 1);
`ifdef DIV_SEQ_CTRL_FAST_PATH_EN
      if (in_div0 | in_ovf) begin
        state_next  = DONE;
        result_next = in_spec_res;
      end else begin
        state_next  = WAIT;
      end
`else
      state_next    = WAIT;
`endif
    end
  end

  assign busy   = (state_reg == WAIT);
  assign dv_en  = (state_reg == WAIT);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign dv_in1 = dv_in1_reg;
  assign dv_in2 = dv_in2_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural unsigned divider model;
// expected latency for special cases follows DIV_SEQ_CTRL_FAST_PATH_EN.
module tb_div_seq_ctrl;
  localparam int L = 4;
`ifdef DIV_SEQ_CTRL_FAST_PATH_EN
  localparam int SPL = 1;
`else
  localparam int SPL = L + 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, dv_en;
  logic [31:0] result, dv_in1, dv_in2, dv_low, dv_high;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Unsigned divider model; garbage on divide-by-zero so forcing is exercised.
  assign dv_low  = (dv_in2 == 32'd0) ? 32'hDEAD_BEEF : dv_in1 / dv_in2;
  assign dv_high = (dv_in2 == 32'd0) ? 32'h0BAD_F00D : dv_in1 % dv_in2;

  div_seq_ctrl #(.DIV_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result), .dv_in1(dv_in1), .dv_in2(dv_in2),
    .dv_en(dv_en), .dv_low(dv_low), .dv_high(dv_high)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op (start for one cycle), tracks WAIT cycles, checks latency/result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [31:0] exp_d1, input logic [31:0] exp_d2, input int exp_lat);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n <= 20) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_dv_en"}, dv_en, 1);
        check({tag, "_dv_in1"}, dv_in1, exp_d1);
        check({tag, "_dv_in2"}, dv_in2, exp_d2);
        n++;
        @(negedge clk);
      end
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_dv_in1_done"}, dv_in1, exp_d1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_result_hold"}, result, exp_res);
    $display("op %s f3=%b a=%h b=%h result=%h latency=%0d", tag, f3, a, b, result, n);
  endtask

  initial begin
    int n;
    bit any_done;
    rst = 1'b1; start = 1'b0; funct3 = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dv_en", dv_en, 0);
    check("rst_result", result, 0);
    check("rst_dv_in1", dv_in1, 0);
    check("rst_dv_in2", dv_in2, 0);

    run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'd7, 32'd2, L + 1);
    run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'd7, 32'd2, L + 1);
    run_op("divu_by0",  3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, SPL);
    run_op("remu_by0",  3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h1234_5678, 32'd0, SPL);
    run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1, SPL);
    run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'd1, SPL);
    run_op("rem_7_m2",  3'b110, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'd7, 32'd2, L + 1);
    run_op("div_7_m2",  3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd7, 32'd2, L + 1);
    run_op("code010",   3'b010, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'hFFFF_FFF9, 32'd2, L + 1);

    // Back-to-back: start held through WAIT and the done cycle.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n <= 20) begin n++; @(negedge clk); end
    check("b2b_first_latency", n, L + 1);
    check("b2b_first_result", result, 32'd14);
    funct3 = 3'b111;
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", busy, 1);
    check("b2b_no_done", done, 0);
    n = 1;
    while (done !== 1'b1 && n <= 20) begin n++; @(negedge clk); end
    check("b2b_second_latency", n, L + 1);
    check("b2b_second_result", result, 32'd2);
    $display("op b2b divu/remu 100/7 result=%h", result);

    // start pulse during WAIT must be ignored.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1 = 32'd9; rs2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n <= 20) begin n++; @(negedge clk); end
    check("ign_latency", n, L + 1);
    check("ign_result", result, 32'd14);
    check("ign_dv_in1", dv_in1, 32'd100);
    @(negedge clk);
    check("ign_no_extra_done", done, 0);
    check("ign_idle_busy", busy, 0);
    $display("op ignore-start divu 100/7 result=%h", result);

    // Reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_dv_en", dv_en, 0);
    any_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) any_done = 1'b1;
    end
    check("mid_rst_no_done", any_done, 0);
    $display("op reset-abort done_seen=%0d", any_done);
    run_op("after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 32'd100, 32'd7, L + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
